// File: rtl/sqrt_rr_sched.sv
// Round-robin front end that time-shares one iterative sqrt unit among N requesters.
// One transaction at a time: grant, strobe the unit, wait out its busy, return the result.
module sqrt_rr_sched #(
   parameter int N       = 4,
   parameter int MAX_CYC = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [N-1:0]   req_i,
   input  logic [8*N-1:0] x_bi,
   output logic [N-1:0]   done_o,
   output logic           err_o,
   output logic [7:0]     y_bo,
   output logic           busy_o,
   output logic           unit_start_o,
   output logic [7:0]     unit_x_bo,
   input  logic           unit_busy_i,
   input  logic [7:0]     unit_y_bi
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   own_q, own_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [N-1:0]    done_q, done_d;
   logic            err_q, err_d;
   logic [7:0]      y_q, y_d;
   logic            start_q, start_d;
   logic [7:0]      ux_q, ux_d;

   logic            gnt_vld;
   logic [IW-1:0]   gnt_idx;
   logic [7:0]      gnt_x;
   logic [IW:0]     sum;
   logic [IW-1:0]   idx;
   logic            wd_exp;

   assign wd_exp = (wd_q == WW'(MAX_CYC - 2));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      wd_d    = wd_q;
      done_d  = '0;
      err_d   = err_q;
      y_d     = y_q;
      start_d = 1'b0;
      ux_d    = ux_q;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt_x   = '0;
      sum     = '0;
      idx     = '0;

      // Search upward from the pointer, wrapping at N; first hit wins.
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         idx = sum[IW-1:0];
         if (!gnt_vld && req_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
            gnt_x   = x_bi[{idx, 3'b000} +: 8];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               own_d   = gnt_idx;
               ux_d    = gnt_x;
               start_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (unit_busy_i) begin
               state_d = S_RUN;
            end else if (wd_exp) begin
               y_d          = 8'hFF;
               err_d        = 1'b1;
               done_d[own_q] = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_RUN: begin
            wd_d = wd_q + 1'b1;
            // A normal finish on the same cycle as the timeout still counts as success.
            if (!unit_busy_i) begin
               y_d          = unit_y_bi;
               err_d        = 1'b0;
               done_d[own_q] = 1'b1;
               state_d      = S_DONE;
            end else if (wd_exp) begin
               y_d          = 8'hFF;
               err_d        = 1'b1;
               done_d[own_q] = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            ptr_d   = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         wd_q    <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         y_q     <= '0;
         start_q <= 1'b0;
         ux_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
         y_q     <= y_d;
         start_q <= start_d;
         ux_q    <= ux_d;
      end
   end

   assign done_o       = done_q;
   assign err_o        = err_q;
   assign y_bo         = y_q;
   assign busy_o       = (state_q != S_IDLE);
   assign unit_start_o = start_q;
   assign unit_x_bo    = ux_q;

endmodule

// File: tb/tb_sqrt_rr_sched.sv
// Bench for sqrt_rr_sched: behavioural sqrt unit with configurable busy length,
// expected completions queued at stimulus time and compared against observed done pulses.
module tb_sqrt_rr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] x   = '0;
   logic [3:0]  done_o;
   logic        err_o;
   logic [7:0]  y_bo;
   logic        busy_o;
   logic        unit_start_o;
   logic [7:0]  unit_x_bo;

   logic        u_busy = 1'b0;
   logic [7:0]  u_y    = '0;
   int          u_cnt  = 0;
   int          u_L    = 4;
   bit          u_hang = 1'b0;

   int cyc = 0;
   int errs = 0;
   int checks = 0;

   typedef struct { logic [3:0] d; logic [7:0] y; logic e; int c; } ev_t;
   typedef struct { logic [7:0] x; int c; } st_t;
   ev_t exp_q[$];
   ev_t obs_q[$];
   st_t st_q[$];
   ev_t mon_ev;
   st_t mon_st;

   sqrt_rr_sched #(.N(4), .MAX_CYC(32)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .x_bi(x),
      .done_o(done_o), .err_o(err_o), .y_bo(y_bo), .busy_o(busy_o),
      .unit_start_o(unit_start_o), .unit_x_bo(unit_x_bo),
      .unit_busy_i(u_busy), .unit_y_bi(u_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] isqrt(input logic [7:0] v);
      logic [7:0] r;
      r = 0;
      for (int i = 0; i < 16; i++) if (i * i <= int'(v)) r = 8'(i);
      return r;
   endfunction

   // Shared unit: busy rises on the edge that samples start and stays high u_L cycles.
   always @(posedge clk) begin
      if (unit_start_o && !u_busy) begin
         u_busy <= 1'b1;
         u_cnt  <= u_L - 1;
         u_y    <= isqrt(unit_x_bo);
      end else if (u_busy && !u_hang) begin
         if (u_cnt == 0) u_busy <= 1'b0;
         else            u_cnt  <= u_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (done_o != 4'b0) begin
         mon_ev.d = done_o; mon_ev.y = y_bo; mon_ev.e = err_o; mon_ev.c = cyc;
         obs_q.push_back(mon_ev);
      end
      if (unit_start_o) begin
         mon_st.x = unit_x_bo; mon_st.c = cyc;
         st_q.push_back(mon_st);
      end
   end

   task automatic push_exp(input logic [3:0] d, input logic [7:0] y, input logic e);
      ev_t ev;
      ev.d = d; ev.y = y; ev.e = e; ev.c = 0;
      exp_q.push_back(ev);
   endtask

   task automatic wait_obs(input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic clear_q;
      exp_q.delete(); obs_q.delete(); st_q.delete();
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b0; req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0h want 0", busy_o); end
      checks++; if (done_o !== 4'b0) begin errs++; $display("FAIL rst_done: got %0h want 0", done_o); end
      checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL rst_err: got %0h want 0", err_o); end
      checks++; if (y_bo !== 8'h0) begin errs++; $display("FAIL rst_y: got %0h want 0", y_bo); end
      checks++; if (unit_start_o !== 1'b0) begin errs++; $display("FAIL rst_start: got %0h want 0", unit_start_o); end
      checks++; if (unit_x_bo !== 8'h0) begin errs++; $display("FAIL rst_ux: got %0h want 0", unit_x_bo); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      clear_q();
   endtask

   task automatic test_single;
      ev_t e, o;
      clear_q();
      x[23:16] = 8'd81; req = 4'b0100;
      push_exp(4'b0100, 8'd9, 1'b0);
      wait_obs(1, 40);
      req = '0;
      repeat (10) @(negedge clk);
      checks++; if (st_q.size() !== 1) begin errs++; $display("FAIL single_starts: got %0d want 1", st_q.size()); end
      checks++; if (obs_q.size() !== 1) begin errs++; $display("FAIL single_dones: got %0d want 1", obs_q.size()); end
      if (st_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (st_q[0].x !== 8'd81) begin errs++; $display("FAIL single_ux: got %0d want 81", st_q[0].x); end
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL single_done: got %b want %b", o.d, e.d); end
         checks++; if (o.y !== e.y) begin errs++; $display("FAIL single_y: got %0d want %0d", o.y, e.y); end
         checks++; if (o.e !== e.e) begin errs++; $display("FAIL single_err: got %0d want %0d", o.e, e.e); end
         // start is seen after the grant edge, done after the 7th edge counting the grant edge as 1
         checks++; if (o.c - st_q[0].c !== 6) begin errs++; $display("FAIL single_lat: got %0d want 6", o.c - st_q[0].c); end
      end
      checks++; if (y_bo !== 8'd9) begin errs++; $display("FAIL single_hold: got %0d want 9", y_bo); end
   endtask

   task automatic test_fairness;
      int own_e[5] = '{0, 1, 2, 3, 0};
      logic [7:0] xs[4] = '{8'd16, 8'd25, 8'd36, 8'd49};
      ev_t e, o;
      int prev_c;
      test_reset();
      x = {xs[3], xs[2], xs[1], xs[0]};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(4'(1 << own_e[i]), 8'(4 + own_e[i]), 1'b0);
      wait_obs(5, 100);
      req = '0;
      repeat (12) @(negedge clk);
      checks++; if (obs_q.size() !== 5) begin errs++; $display("FAIL fair_count: got %0d want 5", obs_q.size()); end
      checks++; if (st_q.size() !== 5) begin errs++; $display("FAIL fair_starts: got %0d want 5", st_q.size()); end
      prev_c = 0;
      for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL fair_done%0d: got %b want %b", i, o.d, e.d); end
         checks++; if (o.y !== e.y) begin errs++; $display("FAIL fair_y%0d: got %0d want %0d", i, o.y, e.y); end
         if (i < st_q.size()) begin
            checks++; if (st_q[i].x !== xs[own_e[i]]) begin errs++; $display("FAIL fair_ux%0d: got %0d want %0d", i, st_q[i].x, xs[own_e[i]]); end
         end
         if (i > 0) begin
            checks++; if (o.c - prev_c !== 8) begin errs++; $display("FAIL fair_gap%0d: got %0d want 8", i, o.c - prev_c); end
         end
         prev_c = o.c;
      end
   endtask

   task automatic test_wrap;
      ev_t e, o;
      clear_q();
      req = 4'b1001;
      push_exp(4'b1000, 8'd7, 1'b0);
      push_exp(4'b0001, 8'd4, 1'b0);
      push_exp(4'b1000, 8'd7, 1'b0);
      wait_obs(3, 60);
      req = '0;
      repeat (12) @(negedge clk);
      checks++; if (obs_q.size() !== 3) begin errs++; $display("FAIL wrap_count: got %0d want 3", obs_q.size()); end
      for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL wrap_done%0d: got %b want %b", i, o.d, e.d); end
      end
   endtask

   task automatic test_watchdog;
      ev_t e, o;
      clear_q();
      u_hang = 1'b1;
      x[15:8] = 8'd100; req = 4'b0010;
      push_exp(4'b0010, 8'hFF, 1'b1);
      wait_obs(1, 60);
      req = '0;
      checks++; if (obs_q.size() !== 1) begin errs++; $display("FAIL wd_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && st_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL wd_done: got %b want %b", o.d, e.d); end
         checks++; if (o.y !== e.y) begin errs++; $display("FAIL wd_y: got %0h want %0h", o.y, e.y); end
         checks++; if (o.e !== e.e) begin errs++; $display("FAIL wd_err: got %0d want %0d", o.e, e.e); end
         checks++; if (o.c - st_q[0].c !== 32) begin errs++; $display("FAIL wd_lat: got %0d want 32", o.c - st_q[0].c); end
      end
      u_hang = 1'b0;
      for (int i = 0; i < 20 && u_busy; i++) @(negedge clk);
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL wd_idle: got %0h want 0", busy_o); end
      clear_q();
      x[23:16] = 8'd144; req = 4'b0100;
      push_exp(4'b0100, 8'd12, 1'b0);
      wait_obs(1, 40);
      req = '0;
      repeat (4) @(negedge clk);
      checks++; if (obs_q.size() !== 1) begin errs++; $display("FAIL wd_next_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d || o.y !== e.y || o.e !== e.e)
            begin errs++; $display("FAIL wd_next: got %b/%0d/%0d want %b/%0d/%0d", o.d, o.y, o.e, e.d, e.y, e.e); end
      end
   endtask

   task automatic test_reset_mid;
      ev_t e, o;
      clear_q();
      x[31:24] = 8'd225; req = 4'b1000;
      for (int i = 0; i < 20 && st_q.size() < 1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b0; req = '0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL mid_busy: got %0h want 0", busy_o); end
      checks++; if (done_o !== 4'b0) begin errs++; $display("FAIL mid_done: got %0h want 0", done_o); end
      checks++; if (y_bo !== 8'h0) begin errs++; $display("FAIL mid_y: got %0h want 0", y_bo); end
      rst = 1'b1;
      for (int i = 0; i < 20 && u_busy; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (obs_q.size() !== 0) begin errs++; $display("FAIL mid_late: got %0d want 0", obs_q.size()); end
      clear_q();
      // pointer back at 0 means requester 1 beats requester 3
      x[15:8] = 8'd100; req = 4'b1010;
      push_exp(4'b0010, 8'd10, 1'b0);
      wait_obs(1, 40);
      req = '0;
      repeat (4) @(negedge clk);
      checks++; if (obs_q.size() !== 1) begin errs++; $display("FAIL mid_ptr_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL mid_ptr: got %b want %b", o.d, e.d); end
      end
   endtask

   task automatic test_operand;
      ev_t e, o;
      clear_q();
      x[15:8] = 8'd64; req = 4'b0010;
      push_exp(4'b0010, 8'd8, 1'b0);
      for (int i = 0; i < 20 && st_q.size() < 1; i++) @(negedge clk);
      @(negedge clk);
      x[15:8] = 8'd100;
      @(negedge clk);
      req = '0;
      wait_obs(1, 30);
      checks++; if (unit_x_bo !== 8'd64) begin errs++; $display("FAIL op_ux: got %0d want 64", unit_x_bo); end
      checks++; if (obs_q.size() !== 1) begin errs++; $display("FAIL op_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o.d !== e.d) begin errs++; $display("FAIL op_done: got %b want %b", o.d, e.d); end
         checks++; if (o.y !== e.y) begin errs++; $display("FAIL op_y: got %0d want %0d", o.y, e.y); end
      end
      repeat (10) @(negedge clk);
      checks++; if (st_q.size() !== 1) begin errs++; $display("FAIL op_starts: got %0d want 1", st_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_watchdog();
      test_reset_mid();
      test_operand();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sqrt_rr_sched.md
# sqrt_rr_sched

Round-robin scheduler that shares one iterative `sqrt` unit between `N` requesters.
- Each requester raises a request carrying an 8-bit operand.
- The scheduler grants one requester, drives the unit's `start_i`/`x_bi`, and waits out the unit's `busy_o`.
- It returns `y_bo` with a one-cycle `done_o` pulse to the owner.
- It sits between the arithmetic front-ends (e.g. the `a + cbrt(b)` path) and the single shared `sqrt` instance.

## Interface
- `N`, default 4: number of requesters (2..8).
- `MAX_CYC`, default 32: watchdog limit, in cycles, for one unit operation.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `req_i`  in  N  per-requester request level.
- `x_bi`  in  8*N  operands; requester i uses bits `[8i+7:8i]`.
- `done_o`  out  N  one-hot, one-cycle completion pulse to the owner.
- `err_o`  out  1  valid with `done_o`; 1 = watchdog abort.
- `y_bo`  out  8  result; valid while `done_o` is high, held until the next completion.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `unit_start_o`  out  1  start strobe to the shared `sqrt` unit.
- `unit_x_bo`  out  8  operand to the unit.
- `unit_busy_i`  in  1  unit `busy_o`.
- `unit_y_bi`  in  8  unit `y_bo`.

## Operation
- **Reset (`rst_i` = 0 at an edge):**
  - State goes to IDLE.
  - Round-robin pointer = 0; watchdog count = 0; owner index = 0.
  - `done_o`, `err_o`, `y_bo`, `unit_start_o`, `unit_x_bo` = 0.
  - Reset mid-operation aborts silently: no `done_o` pulse, no result.
- **States: IDLE, ISSUE, WAIT, RUN, DONE.**
- **IDLE:**
  - If any `req_i` bit is high, select the first set bit searching from the pointer upward, wrapping at `N`.
  - Latch the owner index and its operand into `unit_x_bo`, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:** `unit_start_o` = 1 for exactly this cycle; clear the watchdog; go to WAIT.
- **WAIT:** if `unit_busy_i` = 1, go to RUN; otherwise stay.
- **RUN:** if `unit_busy_i` = 0, register `y_bo` <= `unit_y_bi`, `err_o` <= 0, `done_o[owner]` <= 1, and go to DONE.
- **Watchdog:**
  - Increments every cycle spent in WAIT or RUN.
  - If it reaches `MAX_CYC`-1 without leaving RUN, go to DONE with `y_bo` <= 8'hFF, `err_o` <= 1, `done_o[owner]` <= 1.
- **DONE:** clear `done_o`; set pointer <= owner+1 mod `N`; go to IDLE.
- **Request rules:**
  - `req_i` and `x_bi` matter only in IDLE.
  - The operand is captured at grant; later changes are ignored.
  - A request dropped after grant still completes and pulses `done_o`.
  - A requester keeps `req_i` high until its `done_o`. If `req_i` is still high in the next IDLE, that is a new request arbitrated fairly.
- **Arbitration:** occurs only in IDLE. Requests arriving during a transaction wait; none are lost while held.

## Timing
- Let L = number of cycles the unit holds `busy` high (L ≥ 1; busy rises on the edge that samples start).
- **Edge sequence:**
  - E1: IDLE→ISSUE.
  - E2: unit samples `unit_start_o`.
  - E3: WAIT→RUN.
  - E(3+L): RUN→DONE.
- **Latency:** `done_o`/`y_bo` are valid in the cycle after E(3+L), i.e. L+3 edges after the grant edge.
- **Throughput:** back-to-back transactions take L+4 cycles each (one DONE plus one IDLE arbitration cycle).
- **Outputs:** all registered; no combinational path from `req_i` to any output.
- **Fairness:** with all `N` requesting continuously, grants rotate 0,1,…,N-1,0; no requester waits more than N-1 transactions.

## Test plan
- **Single request:** reset, hold `rst_i` = 0 for 2 cycles, release; `req_i` = 4'b0100, operand2 = 8'd81; unit model L = 4 returns 9.
  - Required: `unit_start_o` pulses once with `unit_x_bo` = 81.
  - Required: `done_o` = 4'b0100 for exactly 1 cycle, 7 edges after grant, with `y_bo` = 9 and `err_o` = 0.
- **Fairness:** `req_i` = 4'b1111 held, operands 16, 25, 36, 49.
  - Required: grants in order 0,1,2,3,0; results 4, 5, 6, 7; consecutive `done_o` pulses 8 cycles apart (L = 4).
- **Wrap-around:**
  - Required: after owner 3 completes with `req_i` = 4'b1001, the next grant goes to 0.
  - Required: after owner 0 completes with `req_i` = 4'b1001, the next grant goes to 3.
- **Watchdog:** unit model holds `busy` high forever.
  - Required: `done_o[owner]` pulses `MAX_CYC` cycles after ISSUE, with `y_bo` = 8'hFF and `err_o` = 1.
  - Required: the scheduler returns to IDLE and serves the next request normally.
- **Reset mid-operation:** assert `rst_i` = 0 while in RUN.
  - Required: next cycle `busy_o` = 0, `done_o` = 0, `y_bo` = 0, pointer = 0.
  - Required: no late `done_o` pulse when the unit's `busy` eventually drops.
- **Operand change and withdrawal:**
  - Stimulus: change operand1 from 64 to 100 one cycle after grant.
  - Required: `unit_x_bo` stays 64 and the result is 8.
  - Stimulus: drop `req_i[1]` during RUN.
  - Required: `done_o[1]` still pulses.
